// File: rtl/bm_dag_pipe_lpm_pkg.sv
// bm_dag_pipe_lpm shared definitions.
// Mode encodings and stage payload widths.
package bm_dag_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ACC  = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;

  // S1 carries a_in, b_in, c, mode
  function automatic int s1_w(input int bits);
    return 3 * bits + 2;
  endfunction

  // S2 carries a, b, c, b_in, mode
  function automatic int s2_w(input int bits);
    return 4 * bits + 2;
  endfunction

endpackage

// File: rtl/bm_dag_pipe_lpm_if.sv
// bm_dag_pipe_lpm beat/result handshake bundle.
// master drives beats and out_ready; slave is the pipe.
interface bm_dag_pipe_lpm_if #(
  parameter int BITS = 8
);

  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a_in;
  logic [BITS-1:0] b_in;
  logic [1:0]      mode;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out;
  logic            out_acc;

  modport master (
    output in_valid, a_in, b_in, mode, out_ready,
    input  in_ready, out_valid, out, out_acc
  );

  modport slave (
    input  in_valid, a_in, b_in, mode, out_ready,
    output in_ready, out_valid, out, out_acc
  );

endinterface

// File: rtl/bm_dag_pipe_stage.sv
// Valid/data register slice with a combinational ready chain.
// Loads when empty or when its own content moves on.
module bm_dag_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  input  logic         ready_next,
  output logic         valid_out,
  output logic [W-1:0] data_out,
  output logic         adv
);

  logic load;

  assign adv  = valid_out & ready_next;
  assign load = !valid_out | adv;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (load) begin
      valid_out <= valid_in;
      if (valid_in) data_out <= data_in;
    end
  end

endmodule

// File: rtl/bm_dag_pipe_lpm.sv
// Three-stage DAG adder/subtractor pipe with accumulate mode.
// S1/S2 are register slices; S3 and the accumulator live here.
module bm_dag_pipe_lpm
  import bm_dag_pkg::*;
#(
  parameter int BITS = 8
) (
  input logic           clock,
  input logic           resetn,
  bm_dag_pipe_lpm_if.slave bus
);

  localparam int W1 = s1_w(BITS);
  localparam int W2 = s2_w(BITS);

  typedef struct packed {
    logic [1:0]      mode;
    logic [BITS-1:0] c;
    logic [BITS-1:0] b;
    logic [BITS-1:0] a;
  } s1_t;

  typedef struct packed {
    logic [1:0]      mode;
    logic [BITS-1:0] bin;
    logic [BITS-1:0] c;
    logic [BITS-1:0] b;
    logic [BITS-1:0] a;
  } s2_t;

  s1_t s1_in;
  s1_t s1_q;
  s2_t s2_in;
  s2_t s2_q;

  logic v1;
  logic v2;
  logic adv1;
  logic adv2;
  logic ready3;

  logic            v3;
  logic [BITS-1:0] out_q;
  logic            acc_flag;
  logic [BITS-1:0] acc;

  logic [BITS-1:0] d;
  logic [BITS-1:0] sum;
  logic            is_acc;
  logic            is_load;
  logic [BITS-1:0] nxt_out;
  logic [BITS-1:0] nxt_acc;
  logic            nxt_flag;

  assign s1_in.a    = bus.a_in;
  assign s1_in.b    = bus.b_in;
  assign s1_in.c    = bus.a_in + bus.b_in;
  assign s1_in.mode = bus.mode;

  bm_dag_pipe_stage #(.W(W1)) u_s1 (
    .clock      (clock),
    .resetn     (resetn),
    .valid_in   (bus.in_valid),
    .data_in    (s1_in),
    .ready_next (!v2 | adv2),
    .valid_out  (v1),
    .data_out   (s1_q),
    .adv        (adv1)
  );

  assign s2_in.a    = s1_q.b + s1_q.c;
  assign s2_in.b    = s1_q.a - s1_q.c;
  assign s2_in.c    = s1_q.c;
  assign s2_in.bin  = s1_q.b;
  assign s2_in.mode = s1_q.mode;

  bm_dag_pipe_stage #(.W(W2)) u_s2 (
    .clock      (clock),
    .resetn     (resetn),
    .valid_in   (v1),
    .data_in    (s2_in),
    .ready_next (ready3),
    .valid_out  (v2),
    .data_out   (s2_q),
    .adv        (adv2)
  );

  assign ready3 = !v3 | bus.out_ready;

  assign d       = s2_q.b + s2_q.bin;
  assign sum     = s2_q.a + s2_q.b + s2_q.c + d;
  assign is_acc  = (s2_q.mode == MODE_ACC);
  assign is_load = (s2_q.mode == MODE_LOAD);

  always_comb begin
    nxt_out  = sum;
    nxt_acc  = acc;
    nxt_flag = 1'b0;
    unique case (1'b1)
      is_acc: begin
        nxt_out  = acc + sum;
        nxt_acc  = acc + sum;
        nxt_flag = 1'b1;
      end
      is_load: begin
        nxt_acc  = sum;
        nxt_flag = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // out/out_acc only change on a load, so they hold while stalled
  always_ff @(posedge clock) begin
    if (!resetn) begin
      v3       <= 1'b0;
      out_q    <= '0;
      acc_flag <= 1'b0;
      acc      <= '0;
    end else if (adv2) begin
      v3       <= 1'b1;
      out_q    <= nxt_out;
      acc_flag <= nxt_flag;
      acc      <= nxt_acc;
    end else if (bus.out_ready) begin
      v3 <= 1'b0;
    end
  end

  assign bus.in_ready  = !v1 | adv1;
  assign bus.out_valid = v3;
  assign bus.out       = out_q;
  assign bus.out_acc   = acc_flag;

endmodule

// File: tb/tb_bm_dag_pipe_lpm.sv
// Bench for bm_dag_pipe_lpm: BITS=8 and BITS=2 instances,
// queue model of 2*(a+b) with running accumulator.
module tb_bm_dag_pipe_lpm;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  bm_dag_pipe_lpm_if #(.BITS(8)) bus8 ();
  bm_dag_pipe_lpm_if #(.BITS(2)) bus2 ();

  bm_dag_pipe_lpm #(.BITS(8)) dut8 (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus8)
  );

  bm_dag_pipe_lpm #(.BITS(2)) dut2 (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: one expected result per accepted beat
  typedef struct {
    int v;
    int f;
  } exp_t;

  exp_t       q[$];
  int         macc;
  bit         held;
  logic [7:0] hout;
  logic       hflag;

  always @(negedge clk) begin
    exp_t e;
    int   s;
    if (!resetn) begin
      q.delete();
      macc = 0;
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(bus8.out_valid), 1);
        chk("hold_out", 32'(bus8.out), 32'(hout));
        chk("hold_acc", 32'(bus8.out_acc), 32'(hflag));
      end
      if (bus8.out_valid) begin
        if (bus8.out_ready) begin
          held = 0;
          if (q.size() == 0) begin
            chk("model_spurious", 1, 0);
          end else begin
            e = q.pop_front();
            chk("model_out", 32'(bus8.out), 32'(e.v));
            chk("model_acc", 32'(bus8.out_acc), 32'(e.f));
          end
        end else begin
          held  = 1;
          hout  = bus8.out;
          hflag = bus8.out_acc;
        end
      end else begin
        held = 0;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        s = (2 * (int'(bus8.a_in) + int'(bus8.b_in))) % 256;
        if (bus8.mode == 2'b01) begin
          macc = (macc + s) % 256;
          e.v = macc;
          e.f = 1;
        end else if (bus8.mode == 2'b10) begin
          macc = s;
          e.v = s;
          e.f = 1;
        end else begin
          e.v = s;
          e.f = 0;
        end
        q.push_back(e);
      end
    end
  end

  int sa[8], sb[8], sm[8], eo[8], ef[8];
  int ta[4], tb[4], te[4];

  // beat i driven in cycle i must appear in cycle i+3
  task automatic run_stream(input int n, input int n2, input string tag);
    for (int cyc = 0; cyc < n + 3; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < n) begin
        bus8.in_valid = 1'b1;
        bus8.a_in     = 8'(sa[cyc]);
        bus8.b_in     = 8'(sb[cyc]);
        bus8.mode     = 2'(sm[cyc]);
      end else begin
        bus8.in_valid = 1'b0;
      end
      if (cyc < n2) begin
        bus2.in_valid = 1'b1;
        bus2.a_in     = 2'(ta[cyc]);
        bus2.b_in     = 2'(tb[cyc]);
        bus2.mode     = 2'b00;
      end else begin
        bus2.in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc < n) chk({tag, "_in_ready"}, 32'(bus8.in_ready), 1);
      if (cyc < 3) begin
        chk($sformatf("%s_lat%0d", tag, cyc), 32'(bus8.out_valid), 0);
      end else begin
        chk($sformatf("%s_valid%0d", tag, cyc - 3),
            32'(bus8.out_valid), 1);
        chk($sformatf("%s_out%0d", tag, cyc - 3),
            32'(bus8.out), 32'(eo[cyc - 3]));
        chk($sformatf("%s_acc%0d", tag, cyc - 3),
            32'(bus8.out_acc), 32'(ef[cyc - 3]));
      end
      if (n2 > 0 && cyc >= 3 && cyc - 3 < n2) begin
        chk($sformatf("%s_w2_valid%0d", tag, cyc - 3),
            32'(bus2.out_valid), 1);
        chk($sformatf("%s_w2_out%0d", tag, cyc - 3),
            32'(bus2.out), 32'(te[cyc - 3]));
      end else if (n2 > 0 && cyc < 3) begin
        chk($sformatf("%s_w2_lat%0d", tag, cyc),
            32'(bus2.out_valid), 0);
      end
    end
    bus8.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    int pa[4], pb[4], pe[4];

    bus8.in_valid  = 1'b0;
    bus8.a_in      = '0;
    bus8.b_in      = '0;
    bus8.mode      = 2'b00;
    bus8.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.a_in      = '0;
    bus2.b_in      = '0;
    bus2.mode      = 2'b00;
    bus2.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(bus8.out_valid), 0);
    chk("reset_out", 32'(bus8.out), 0);
    chk("reset_out_acc", 32'(bus8.out_acc), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(bus8.in_ready), 1);

    // plain streaming, both widths
    sa[0] = 3;   sb[0] = 5;   sm[0] = 0; eo[0] = 16; ef[0] = 0;
    sa[1] = 200; sb[1] = 100; sm[1] = 0; eo[1] = 88; ef[1] = 0;
    ta[0] = 1; tb[0] = 2; te[0] = 2;
    ta[1] = 3; tb[1] = 3; te[1] = 0;
    run_stream(2, 2, "pass");

    // load, accumulate chain, pass, then acc unchanged
    sa[0] = 1; sb[0] = 1; sm[0] = 2; eo[0] = 4;  ef[0] = 1;
    sa[1] = 2; sb[1] = 0; sm[1] = 1; eo[1] = 8;  ef[1] = 1;
    sa[2] = 0; sb[2] = 3; sm[2] = 1; eo[2] = 14; ef[2] = 1;
    sa[3] = 5; sb[3] = 5; sm[3] = 0; eo[3] = 20; ef[3] = 0;
    sa[4] = 0; sb[4] = 0; sm[4] = 1; eo[4] = 14; ef[4] = 1;
    run_stream(5, 0, "acc");

    // stall with four beats offered
    pa[0] = 10; pb[0] = 1; pe[0] = 22;
    pa[1] = 20; pb[1] = 2; pe[1] = 44;
    pa[2] = 30; pb[2] = 3; pe[2] = 66;
    pa[3] = 40; pb[3] = 4; pe[3] = 88;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.mode      = 2'b00;
    bus8.a_in      = 8'(pa[0]);
    bus8.b_in      = 8'(pb[0]);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc < 3) begin
        chk($sformatf("stall_fill_ready%0d", cyc), 32'(bus8.in_ready), 1);
        chk($sformatf("stall_fill_valid%0d", cyc), 32'(bus8.out_valid), 0);
      end else if (cyc < 6) begin
        chk($sformatf("stall_full_ready%0d", cyc), 32'(bus8.in_ready), 0);
        chk($sformatf("stall_full_valid%0d", cyc), 32'(bus8.out_valid), 1);
        chk($sformatf("stall_full_out%0d", cyc), 32'(bus8.out), 22);
      end else begin
        if (cyc == 6) chk("stall_release_ready", 32'(bus8.in_ready), 1);
        chk($sformatf("drain_valid%0d", cyc - 6), 32'(bus8.out_valid), 1);
        chk($sformatf("drain_out%0d", cyc - 6), 32'(bus8.out),
            32'(pe[cyc - 6]));
      end
      @(posedge clk);
      #1;
      if (cyc < 3) begin
        bus8.a_in = 8'(pa[cyc + 1]);
        bus8.b_in = 8'(pb[cyc + 1]);
      end
      if (cyc == 5) bus8.out_ready = 1'b1;
      if (cyc == 6) bus8.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("drain_empty", 32'(bus8.out_valid), 0);

    // fill and stall, then reset
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus8.in_valid = 1'b1;
      bus8.a_in     = 8'd1;
      bus8.b_in     = 8'd1;
      bus8.mode     = 2'b01;
      @(negedge clk);
      chk($sformatf("rst_fill_ready%0d", i), 32'(bus8.in_ready), 1);
      @(posedge clk);
      #1;
    end
    bus8.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_full_ready", 32'(bus8.in_ready), 0);
    chk("rst_full_valid", 32'(bus8.out_valid), 1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus8.out_valid), 0);
    chk("post_rst_out", 32'(bus8.out), 0);
    chk("post_rst_ready", 32'(bus8.in_ready), 1);
    chk("post_rst_acc_flag", 32'(bus8.out_acc), 0);

    sa[0] = 1; sb[0] = 0; sm[0] = 1; eo[0] = 2; ef[0] = 1;
    run_stream(1, 0, "acc_clr");

    @(negedge clk);
    chk("model_drained", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
